// File: rtl/bnn_pkg.sv
// Shared constants and emit-state encoding for the BNN VAD front end.
package bnn_pkg;
    localparam int MFCC_W    = 16;
    localparam int N_COEF    = 40;
    localparam int K_CONV    = 5;
    localparam int N_WIN     = N_COEF - K_CONV + 1;
    localparam int WIN_IDX_W = 6;

    typedef enum logic {
        ST_IDLE,
        ST_EMIT
    } emit_state_t;
endpackage

// File: rtl/mfcc_bank.sv
// One frame of MFCC coefficients: single write port, K-wide combinational window read at rbase.
module mfcc_bank #(
    parameter int DATA_W = bnn_pkg::MFCC_W,
    parameter int N_COEF = bnn_pkg::N_COEF,
    parameter int K      = bnn_pkg::K_CONV,
    parameter int AW     = bnn_pkg::WIN_IDX_W
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [AW-1:0]         rbase,
    output logic [K*DATA_W-1:0]   rdata
);
    // Contents are deliberately not reset; full flags in the parent qualify them.
    logic [DATA_W-1:0] mem [N_COEF];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_tap
            assign rdata[gi*DATA_W +: DATA_W] = mem[rbase + AW'(gi)];
        end
    endgenerate
endmodule

// File: rtl/mfcc_window_tx.sv
// Buffers 40-coefficient MFCC frames and streams 36 stride-1 windows of 5, one per cycle.
// Define MFCC_WIN_DBUF_EN for ping-pong double buffering; otherwise a single bank is built.
module mfcc_window_tx #(
    parameter int DATA_W = bnn_pkg::MFCC_W,
    parameter int N_COEF = bnn_pkg::N_COEF,
    parameter int K      = bnn_pkg::K_CONV
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic                            in_valid,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            in_ready,
    output logic                            win_wr_en,
    output logic [K*DATA_W-1:0]             win_data,
    output logic [bnn_pkg::WIN_IDX_W-1:0]   win_idx,
    output logic                            win_first,
    output logic                            win_last,
    output logic                            busy
);
    localparam int N_WIN = N_COEF - K + 1;
    localparam int AW    = bnn_pkg::WIN_IDX_W;
`ifdef MFCC_WIN_DBUF_EN
    localparam int N_BANK = 2;
`else
    localparam int N_BANK = 1;
`endif
    localparam bit DBUF = (N_BANK == 2);

    import bnn_pkg::*;

    emit_state_t           state_reg;
    logic [AW-1:0]         wr_cnt_reg;
    logic [AW-1:0]         idx_reg;
    logic                  wr_bank_reg;
    logic                  rd_bank_reg;
    logic [1:0]            full_reg;
    logic                  win_wr_en_reg;
    logic [AW-1:0]         win_idx_reg;
    logic [K*DATA_W-1:0]   win_data_reg;
    logic [K*DATA_W-1:0]   bank_rdata [2];
    logic [AW-1:0]         rd_base;
    logic                  accept;

    assign in_ready = !full_reg[wr_bank_reg];
    assign accept   = in_valid && in_ready;
    // idx_reg reaches N_WIN in the final emit cycle; read base 0 there to stay inside the bank.
    assign rd_base  = (state_reg == ST_EMIT && idx_reg < AW'(N_WIN)) ? idx_reg : '0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            if (gi < N_BANK) begin : g_inst
                mfcc_bank #(
                    .DATA_W(DATA_W),
                    .N_COEF(N_COEF),
                    .K     (K),
                    .AW    (AW)
                ) u_bank (
                    .clk  (clk),
                    .we   (accept && !flush && wr_bank_reg == 1'(gi)),
                    .waddr(wr_cnt_reg),
                    .wdata(in_data),
                    .rbase(rd_base),
                    .rdata(bank_rdata[gi])
                );
            end else begin : g_none
                assign bank_rdata[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            wr_cnt_reg    <= '0;
            idx_reg       <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            full_reg      <= '0;
            win_wr_en_reg <= 1'b0;
            win_idx_reg   <= '0;
            win_data_reg  <= '0;
        end else if (flush) begin
            state_reg     <= ST_IDLE;
            wr_cnt_reg    <= '0;
            idx_reg       <= '0;
            wr_bank_reg   <= 1'b0;
            rd_bank_reg   <= 1'b0;
            full_reg      <= '0;
            win_wr_en_reg <= 1'b0;
        end else begin
            // Set only hits an empty bank and clear only a full one, so they never collide.
            if (accept) begin
                if (wr_cnt_reg == AW'(N_COEF - 1)) begin
                    wr_cnt_reg            <= '0;
                    full_reg[wr_bank_reg] <= 1'b1;
                    wr_bank_reg           <= DBUF ? ~wr_bank_reg : 1'b0;
                end else begin
                    wr_cnt_reg <= wr_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (full_reg[rd_bank_reg]) begin
                        state_reg     <= ST_EMIT;
                        win_wr_en_reg <= 1'b1;
                        win_idx_reg   <= '0;
                        win_data_reg  <= bank_rdata[rd_bank_reg];
                        idx_reg       <= AW'(1);
                    end
                end
                ST_EMIT: begin
                    if (idx_reg == AW'(N_WIN)) begin
                        state_reg             <= ST_IDLE;
                        win_wr_en_reg         <= 1'b0;
                        idx_reg               <= '0;
                        full_reg[rd_bank_reg] <= 1'b0;
                        rd_bank_reg           <= DBUF ? ~rd_bank_reg : 1'b0;
                    end else begin
                        win_wr_en_reg <= 1'b1;
                        win_idx_reg   <= idx_reg;
                        win_data_reg  <= bank_rdata[rd_bank_reg];
                        idx_reg       <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign win_wr_en = win_wr_en_reg;
    assign win_idx   = win_idx_reg;
    assign win_data  = win_data_reg;
    assign win_first = win_wr_en_reg && (win_idx_reg == '0);
    assign win_last  = win_wr_en_reg && (win_idx_reg == AW'(N_WIN - 1));
    assign busy      = (|full_reg) || (state_reg == ST_EMIT);
endmodule
